// File: rtl/pos_pkg.sv
// pos_pkg: shared definitions for the velocity differentiator.
//   state_t      - controller states
//   SCALE_DEF    - default gain applied to the velocity difference
//   DIV_W_DEF    - default dividend width / divider iteration count
//   A_MAX, A_MIN - 16-bit signed saturation limits for the result
package pos_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      DIFF,
      DIV,
      SAT
   } state_t;

   localparam int unsigned SCALE_DEF = 1000;
   localparam int unsigned DIV_W_DEF = 48;

   localparam logic signed [15:0] A_MAX = 16'sh7FFF;
   localparam logic signed [15:0] A_MIN = 16'sh8000;

endpackage

// File: rtl/div_restoring.sv
// div_restoring: unsigned sequential restoring divider, DIV_W / 16 bits.
//   clk, rst  - clock, asynchronous active-high reset
//   start     - load dividend/divisor; the first quotient bit is produced
//               on the same edge
//   dividend  - DIV_W-bit unsigned dividend
//   divisor   - 16-bit unsigned divisor (non-zero)
//   quotient  - DIV_W-bit quotient, held after completion
//   done      - one-cycle pulse after the DIV_W-th iteration
module div_restoring #(
   parameter int unsigned DIV_W = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [15:0]      divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);

   localparam int unsigned CW = $clog2(DIV_W + 1);

   logic [16:0]      rem_q, rem_d;
   logic [DIV_W-1:0] quo_q, quo_d;
   logic [15:0]      dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;

   logic [16:0]      src_rem;
   logic [DIV_W-1:0] src_quo;
   logic [15:0]      src_dvs;
   logic [17:0]      trial;
   logic             fits;
   logic             step;

   always_comb begin
      // On start the operands come straight from the ports so that the
      // iteration count lines up with the loading edge.
      src_rem = start ? '0 : rem_q;
      src_quo = start ? dividend : quo_q;
      src_dvs = start ? divisor : dvs_q;
      trial   = {src_rem, src_quo[DIV_W-1]};
      fits    = (trial >= {2'b00, src_dvs});
      step    = start || (cnt_q != '0);

      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;

      if (step) begin
         rem_d  = fits ? 17'(trial - {2'b00, src_dvs}) : trial[16:0];
         quo_d  = {src_quo[DIV_W-2:0], fits};
         dvs_d  = src_dvs;
         cnt_d  = start ? CW'(DIV_W - 1) : (cnt_q - CW'(1));
         done_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign done     = done_q;

endmodule

// File: rtl/diferenciador_vel.sv
// diferenciador_vel: acceleration from successive velocity samples,
// a = (v - v_prev) * SCALE / dt, saturated to 16 bits signed.
//   clk, rst - clock, asynchronous active-high reset
//   v        - signed 32-bit velocity sample
//   dt       - unsigned 16-bit sample interval (ticks)
//   enable   - start pulse, only accepted in IDLE
//   a        - signed acceleration result, held between updates
//   busy     - high while an accepted operation is in progress
//   valid    - one-cycle pulse when a is updated
//   err      - one-cycle pulse with valid when dt was zero
module diferenciador_vel
   import pos_pkg::*;
#(
   parameter int unsigned SCALE = SCALE_DEF,
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] v,
   input  logic [15:0] dt,
   input  logic        enable,
   output logic [15:0] a,
   output logic        busy,
   output logic        valid,
   output logic        err
);

   localparam logic [15:0]      SCALE16 = 16'(SCALE);
   localparam logic [DIV_W-1:0] Q_POS   = DIV_W'(32767);
   localparam logic [DIV_W-1:0] Q_NEG   = DIV_W'(32768);

   state_t      state_q, state_d;
   logic [31:0] v_lat_q, v_lat_d;
   logic [15:0] dt_lat_q, dt_lat_d;
   logic [31:0] v_prev_q, v_prev_d;
   logic        primed_q, primed_d;
   logic        sign_q, sign_d;
   logic        errp_q, errp_d;
   logic [15:0] a_q, a_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [32:0]      diff;
   logic [32:0]      mag;
   logic [DIV_W-1:0] dividend;
   logic [DIV_W-1:0] quotient;
   logic             start;
   logic             done;
   logic [15:0]      a_sat;

   div_restoring #(.DIV_W(DIV_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (dt_lat_q),
      .quotient (quotient),
      .done     (done)
   );

   always_comb begin
      diff     = {v_lat_q[31], v_lat_q} - {v_prev_q[31], v_prev_q};
      mag      = diff[32] ? (~diff + 33'd1) : diff;
      dividend = DIV_W'(49'(mag) * 49'(SCALE16));

      if (sign_q)
         a_sat = (quotient > Q_NEG) ? A_MIN : 16'(~quotient[15:0] + 16'd1);
      else
         a_sat = (quotient > Q_POS) ? A_MAX : quotient[15:0];

      state_d  = state_q;
      v_lat_d  = v_lat_q;
      dt_lat_d = dt_lat_q;
      v_prev_d = v_prev_q;
      primed_d = primed_q;
      sign_d   = sign_q;
      errp_d   = errp_q;
      a_d      = a_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      start    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               v_lat_d  = v;
               dt_lat_d = dt;
               state_d  = primed_q ? DIFF : PRIME;
            end
         end
         PRIME: begin
            v_prev_d = v_lat_q;
            primed_d = 1'b1;
            a_d      = '0;
            valid_d  = 1'b1;
            state_d  = IDLE;
         end
         DIFF: begin
            sign_d   = diff[32];
            v_prev_d = v_lat_q;
            // A zero interval bypasses the divider and reports through SAT,
            // which keeps the result/valid/err update in one place.
            if (dt_lat_q == '0) begin
               errp_d  = 1'b1;
               state_d = SAT;
            end else begin
               errp_d  = 1'b0;
               start   = 1'b1;
               state_d = DIV;
            end
         end
         DIV: begin
            if (done) state_d = SAT;
         end
         SAT: begin
            a_d     = errp_q ? '0 : a_sat;
            err_d   = errp_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         v_lat_q  <= '0;
         dt_lat_q <= '0;
         v_prev_q <= '0;
         primed_q <= 1'b0;
         sign_q   <= 1'b0;
         errp_q   <= 1'b0;
         a_q      <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         v_lat_q  <= v_lat_d;
         dt_lat_q <= dt_lat_d;
         v_prev_q <= v_prev_d;
         primed_q <= primed_d;
         sign_q   <= sign_d;
         errp_q   <= errp_d;
         a_q      <= a_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign a     = a_q;
   assign busy  = (state_q != IDLE);
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_diferenciador_vel.sv
// tb_diferenciador_vel: directed vectors with hand-computed results pushed
// into a scoreboard queue; a monitor pops and compares on every valid pulse,
// including the edge distance from acceptance to valid.
module tb_diferenciador_vel;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] v = '0;
   logic [15:0] dt = '0;
   logic        enable = 1'b0;
   logic [15:0] a;
   logic        busy;
   logic        valid;
   logic        err;

   typedef struct {
      int ea;
      bit ee;
      int lat;
      int e0;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   diferenciador_vel #(.SCALE(1000), .DIV_W(48)) dut (
      .clk    (clk),
      .rst    (rst),
      .v      (v),
      .dt     (dt),
      .enable (enable),
      .a      (a),
      .busy   (busy),
      .valid  (valid),
      .err    (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst && valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid=1 a=%0d, expected no valid (t=%0t)",
                     $signed(a), $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("a", int'($signed(a)), e.ea);
            chk("err", int'(err), int'(e.ee));
            chk("latency", cyc - e.e0, e.lat);
         end
      end
   end

   task automatic op(input int vv, input int dd, input int ea, input bit ee,
                     input int lat, input bit poke);
      bit fin;
      @(negedge clk);
      v      = vv;
      dt     = 16'(dd);
      enable = 1'b1;
      sb.push_back('{ea: ea, ee: ee, lat: lat, e0: cyc + 1});
      @(negedge clk);
      enable = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      if (poke) begin
         // Extra enables and changed inputs while busy must be ignored.
         repeat (4) @(negedge clk);
         v      = -7777;
         dt     = 16'd3;
         enable = 1'b1;
         @(negedge clk);
         enable = 1'b0;
         repeat (10) @(negedge clk);
         enable = 1'b1;
         @(negedge clk);
         enable = 1'b0;
      end
      fin = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) begin
            fin = 1'b1;
            break;
         end
      end
      if (!fin) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: got no valid within 120 cycles, expected a=%0d", ea);
         sb.delete();
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_a", int'(a), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;

      op(1000, 0, 0, 1'b0, 1, 1'b0);            // prime, dt ignored
      op(3000, 100, 20000, 1'b0, 50, 1'b1);     // 2000*1000/100
      op(1000, 100, -20000, 1'b0, 50, 1'b0);
      op(0, 100, -10000, 1'b0, 50, 1'b0);       // -1000*1000/100
      op(0, 100, 0, 1'b0, 50, 1'b0);            // zero difference
      op(100000, 1, 32767, 1'b0, 50, 1'b0);     // 1e8 saturates high
      op(0, 1, -32768, 1'b0, 50, 1'b0);
      op(-100000, 1, -32768, 1'b0, 50, 1'b0);   // -1e8 saturates low
      op(0, 1, 32767, 1'b0, 50, 1'b0);
      op(500, 0, 0, 1'b1, 2, 1'b0);             // dt==0, v_prev becomes 500
      op(1500, 10, 32767, 1'b0, 50, 1'b0);      // 1000*1000/10 = 100000
      op(2500, 1000, 1000, 1'b0, 50, 1'b0);     // 1000*1000/1000
      op(2503, 7, 428, 1'b0, 50, 1'b0);         // 3000/7 truncated
      op(2500, 7, -428, 1'b0, 50, 1'b0);

      // Asynchronous reset in the middle of a division.
      @(negedge clk);
      v      = 9000;
      dt     = 16'd3;
      enable = 1'b1;
      @(posedge clk);
      #1 enable = 1'b0;
      repeat (20) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_a", int'(a), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_err", int'(err), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);               // monitor flags any stray valid

      op(777, 5, 0, 1'b0, 1, 1'b0);             // primes again after reset
      op(787, 5, 2000, 1'b0, 50, 1'b0);         // 10*1000/5
      repeat (60) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
